// File: rtl/rx_frame_ctrl.sv
// UART receive frame sequencer: start-bit qualification, mid-bit sampling, shift/load strobes and byte-ready handshake.
// Optional parity checking (extra PARITY state and parity_err output) is compiled in with `define RX_PARITY_EN.
module rx_frame_ctrl #(
  parameter int OVS        = 16,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic rxd,
  output logic shift_en,
  output logic sample,
  output logic load,
  output logic rx_ready,
  input  logic rx_ack,
  output logic frame_err,
  output logic overrun,
  input  logic err_clr,
`ifdef RX_PARITY_EN
  output logic parity_err,
`endif
  output logic busy
);

  localparam int TW = $clog2(OVS);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] TICK_END  = TW'(OVS - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

`ifdef RX_PARITY_EN
  localparam logic PAR_SENSE = (PARITY_ODD != 0);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  logic xor_acc;
  logic par_acc;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        state;
  logic [TW-1:0] tick_cnt;
  logic [BW-1:0] bit_cnt;
  logic          stop_err;

  // Handshake updates sit before the frame logic so that a frame completing on
  // the same edge as rx_ack / err_clr overrides them (new byte pending, set wins).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      stop_err  <= 1'b0;
      shift_en  <= 1'b0;
      sample    <= 1'b0;
      load      <= 1'b0;
      rx_ready  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
`ifdef RX_PARITY_EN
      xor_acc    <= 1'b0;
      par_acc    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      shift_en <= 1'b0;
      load     <= 1'b0;
      if (rx_ack && rx_ready) rx_ready <= 1'b0;
      if (err_clr) overrun <= 1'b0;

      if (tick) begin
        case (state)
          IDLE: begin
            if (!rxd) begin
              state    <= START;
              tick_cnt <= '0;
              busy     <= 1'b1;
            end
          end
          START: begin
            if (tick_cnt == TICK_MID) begin
              if (rxd) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                state    <= DATA;
                tick_cnt <= '0;
                bit_cnt  <= '0;
                stop_err <= 1'b0;
`ifdef RX_PARITY_EN
                xor_acc  <= 1'b0;
`endif
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          DATA: begin
            if (tick_cnt == TICK_END) begin
              shift_en <= 1'b1;
              sample   <= rxd;
              tick_cnt <= '0;
`ifdef RX_PARITY_EN
              xor_acc  <= xor_acc ^ rxd;
`endif
              if (bit_cnt == LAST_DATA) begin
                bit_cnt <= '0;
`ifdef RX_PARITY_EN
                state   <= PARITY;
`else
                state   <= STOP;
`endif
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
`ifdef RX_PARITY_EN
          PARITY: begin
            if (tick_cnt == TICK_END) begin
              par_acc  <= (xor_acc ^ rxd) != PAR_SENSE;
              tick_cnt <= '0;
              state    <= STOP;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
`endif
          STOP: begin
            if (tick_cnt == TICK_END) begin
              tick_cnt <= '0;
              // Leave mid stop bit so the next start edge is never missed.
              if (bit_cnt == LAST_STOP) begin
                load      <= 1'b1;
                rx_ready  <= 1'b1;
                frame_err <= stop_err | ~rxd;
`ifdef RX_PARITY_EN
                parity_err <= par_acc;
`endif
                if (rx_ready && !rx_ack) overrun <= 1'b1;
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                stop_err <= stop_err | ~rxd;
                bit_cnt  <= bit_cnt + BW'(1);
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Directed testbench for rx_frame_ctrl (OVS=16, 8N1); parity cases run when RX_PARITY_EN is defined.
module tb_rx_frame_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick = 1'b0;
  logic rxd = 1'b1;
  logic rx_ack = 1'b0;
  logic err_clr = 1'b0;
  logic shift_en, sample, load, rx_ready, frame_err, overrun, busy;
`ifdef RX_PARITY_EN
  logic parity_err;
`endif

  int checks = 0;
  int errors = 0;
  int tick_idx = 0;
  int shift_total = 0;
  int load_total = 0;
  int shift_tick [0:255];
  logic shift_bit [0:255];

  rx_frame_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .rxd       (rxd),
    .shift_en  (shift_en),
    .sample    (sample),
    .load      (load),
    .rx_ready  (rx_ready),
    .rx_ack    (rx_ack),
    .frame_err (frame_err),
    .overrun   (overrun),
    .err_clr   (err_clr),
`ifdef RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Logs every strobe with the index of the tick that caused it.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (shift_en && shift_total < 256) begin
        shift_tick[shift_total] = tick_idx;
        shift_bit[shift_total]  = sample;
        shift_total++;
      end
      if (load) load_total++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tickOnce(input logic ack);
    repeat (3) @(negedge clk);
    tick = 1'b1;
    rx_ack = ack;
    tick_idx++;
    @(negedge clk);
    tick = 1'b0;
    rx_ack = 1'b0;
  endtask

  task automatic idleTicks(input int n);
    rxd = 1'b1;
    repeat (n) tickOnce(1'b0);
  endtask

  // Drives one frame; the stop bit is held only up to its mid-bit sample.
  task automatic applyStimulus(input logic [7:0] data, input logic stop_val, input logic par_val,
                               input logic ack_at_end, output int start_idx);
    start_idx = tick_idx + 1;
    rxd = 1'b0;
    repeat (16) tickOnce(1'b0);
    for (int i = 0; i < 8; i++) begin
      rxd = data[i];
      repeat (16) tickOnce(1'b0);
    end
`ifdef RX_PARITY_EN
    rxd = par_val;
    repeat (16) tickOnce(1'b0);
`endif
    rxd = stop_val;
    repeat (8) tickOnce(1'b0);
    tickOnce(ack_at_end);
    rxd = 1'b1;
  endtask

  task automatic checkFrame(input string tag, input logic [7:0] data, input int start_idx,
                            input int sb, input int lb);
    logic [7:0] got;
    int bad_gaps;
    got = '0;
    bad_gaps = 0;
    checkOutput({tag, " shift count"}, shift_total - sb, 8);
    checkOutput({tag, " first shift tick"}, shift_tick[sb] - start_idx, 24);
    for (int i = 0; i < 8; i++) begin
      got[i] = shift_bit[sb + i];
      if (i > 0 && (shift_tick[sb + i] - shift_tick[sb + i - 1]) != 16) bad_gaps++;
    end
    checkOutput({tag, " shift spacing errors"}, bad_gaps, 0);
    checkOutput({tag, " sampled byte"}, {24'd0, got}, {24'd0, data});
    checkOutput({tag, " load count"}, load_total - lb, 1);
  endtask

  task automatic ackPulse();
    @(negedge clk);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  initial begin
    int s, sb, lb;

    $display("[TB] reset");
    repeat (3) @(negedge clk);
    checkOutput("reset shift_en", shift_en, 0);
    checkOutput("reset sample", sample, 0);
    checkOutput("reset load", load, 0);
    checkOutput("reset rx_ready", rx_ready, 0);
    checkOutput("reset frame_err", frame_err, 0);
    checkOutput("reset overrun", overrun, 0);
    checkOutput("reset busy", busy, 0);
    rst_n = 1'b1;
    idleTicks(4);

    $display("[TB] clean frame 0xA5");
    sb = shift_total; lb = load_total;
    applyStimulus(8'hA5, 1'b1, ^8'hA5, 1'b0, s);
    checkFrame("A5", 8'hA5, s, sb, lb);
    checkOutput("A5 rx_ready", rx_ready, 1);
    checkOutput("A5 frame_err", frame_err, 0);
    checkOutput("A5 busy after load", busy, 0);
    checkOutput("A5 overrun", overrun, 0);
    @(negedge clk);
    checkOutput("A5 load single pulse", load, 0);
    ackPulse();
    checkOutput("A5 rx_ready after ack", rx_ready, 0);
    idleTicks(8);

    $display("[TB] false start");
    sb = shift_total; lb = load_total;
    rxd = 1'b0;
    repeat (4) tickOnce(1'b0);
    rxd = 1'b1;
    repeat (4) tickOnce(1'b0);
    checkOutput("false start busy before mid", busy, 1);
    tickOnce(1'b0);
    checkOutput("false start busy at mid", busy, 0);
    idleTicks(8);
    checkOutput("false start shifts", shift_total - sb, 0);
    checkOutput("false start loads", load_total - lb, 0);
    checkOutput("false start rx_ready", rx_ready, 0);

    $display("[TB] bad stop bit then clean frame");
    sb = shift_total; lb = load_total;
    applyStimulus(8'h00, 1'b0, ^8'h00, 1'b0, s);
    checkFrame("00", 8'h00, s, sb, lb);
    checkOutput("00 rx_ready", rx_ready, 1);
    checkOutput("00 frame_err", frame_err, 1);
    idleTicks(8);
    ackPulse();
    checkOutput("00 rx_ready after ack", rx_ready, 0);
    checkOutput("00 frame_err held until load", frame_err, 1);
    sb = shift_total; lb = load_total;
    applyStimulus(8'h3C, 1'b1, ^8'h3C, 1'b0, s);
    checkFrame("3C", 8'h3C, s, sb, lb);
    checkOutput("3C frame_err", frame_err, 0);
    ackPulse();
    idleTicks(8);

    $display("[TB] overrun");
    applyStimulus(8'h11, 1'b1, ^8'h11, 1'b0, s);
    checkOutput("11 overrun", overrun, 0);
    idleTicks(8);
    sb = shift_total; lb = load_total;
    applyStimulus(8'h22, 1'b1, ^8'h22, 1'b0, s);
    checkFrame("22", 8'h22, s, sb, lb);
    checkOutput("22 overrun", overrun, 1);
    checkOutput("22 rx_ready", rx_ready, 1);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checkOutput("err_clr overrun", overrun, 0);
    checkOutput("err_clr rx_ready", rx_ready, 1);
    idleTicks(8);

    $display("[TB] ack coincident with load");
    sb = shift_total; lb = load_total;
    applyStimulus(8'h33, 1'b1, ^8'h33, 1'b1, s);
    checkFrame("33", 8'h33, s, sb, lb);
    checkOutput("33 rx_ready", rx_ready, 1);
    checkOutput("33 overrun", overrun, 0);
    ackPulse();
    checkOutput("33 rx_ready after ack", rx_ready, 0);
    idleTicks(8);

    $display("[TB] reset mid frame");
    rxd = 1'b0;
    repeat (16) tickOnce(1'b0);
    for (int i = 0; i < 4; i++) begin
      rxd = i[0] ? 1'b1 : 1'b0;
      repeat (16) tickOnce(1'b0);
    end
    rxd = 1'b1;
    repeat (8) tickOnce(1'b0);
    lb = load_total;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset busy", busy, 0);
    checkOutput("midreset rx_ready", rx_ready, 0);
    checkOutput("midreset shift_en", shift_en, 0);
    checkOutput("midreset sample", sample, 0);
    checkOutput("midreset frame_err", frame_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idleTicks(12);
    checkOutput("midreset no load", load_total - lb, 0);
    sb = shift_total; lb = load_total;
    applyStimulus(8'h5A, 1'b1, ^8'h5A, 1'b0, s);
    checkFrame("5A", 8'h5A, s, sb, lb);
    checkOutput("5A rx_ready", rx_ready, 1);
    checkOutput("5A frame_err", frame_err, 0);
    ackPulse();
    idleTicks(8);

`ifdef RX_PARITY_EN
    $display("[TB] parity");
    applyStimulus(8'h07, 1'b1, 1'b1, 1'b0, s);
    checkOutput("07 good parity_err", parity_err, 0);
    ackPulse();
    idleTicks(8);
    applyStimulus(8'h07, 1'b1, 1'b0, 1'b0, s);
    checkOutput("07 bad parity_err", parity_err, 1);
    checkOutput("07 bad frame_err", frame_err, 0);
    ackPulse();
    idleTicks(8);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_frame_ctrl.md
Name: rx_frame_ctrl

Overview:
- Frame sequencer for the UART receive path.
- Consumes the oversampled baud strobe and the filtered serial line. Detects and qualifies the start bit, times mid-bit sampling, and drives shift/load strobes into the RX shift register.
- Owns the byte-ready handshake and per-frame status to the consumer.
- Sits between the baud generator / input filter and the shift register / host logic.

Parameters:
- OVS, 16, oversample ticks per bit period (even, >=4)
- DATA_BITS, 8, data bits per frame (5..9), LSB first
- STOP_BITS, 1, stop bits per frame (1 or 2)
- PARITY_ODD, 0, parity sense when parity is compiled in (0=even, 1=odd)

Ports:
- CLK  in  1  system clock, all logic rising-edge
- RST_N  in  1  asynchronous active-low reset
- TICK  in  1  oversample strobe, one CLK cycle wide, OVS per bit
- RXD  in  1  filtered, synchronised serial line (idle high)
- SHIFT_EN  out  1  one-cycle pulse: shift register captures SAMPLE
- SAMPLE  out  1  mid-bit sampled line value, valid with SHIFT_EN
- LOAD  out  1  one-cycle pulse: frame complete, shift register contents are the byte
- RX_READY  out  1  byte available, held until acknowledged
- RX_ACK  in  1  consumer acknowledge, one cycle
- FRAME_ERR  out  1  stop-bit error for the frame flagged by RX_READY
- OVERRUN  out  1  sticky: frame completed while RX_READY was still pending
- ERR_CLR  in  1  clears OVERRUN
- BUSY  out  1  high in any state other than IDLE

Behaviour:
- Reset: state IDLE; tick and bit counters 0; all outputs 0. Reset mid-frame aborts the frame with no LOAD.
- All outputs are registered. Strobes assert in the CLK cycle after the qualifying TICK cycle.
- Counters advance only on TICK. With no TICK, state is frozen.
- tick_cnt is $clog2(OVS) bits, 0..OVS-1. bit_cnt is $clog2(DATA_BITS+1) bits.
- IDLE:
  - TICK with RXD=0 -> START, tick_cnt=0.
  - RXD=0 without TICK: no action.
- START:
  - Each TICK increments tick_cnt.
  - At tick_cnt==OVS/2-1 (mid start bit): RXD=1 is a false start -> IDLE, no strobes; RXD=0 -> DATA, tick_cnt=0, bit_cnt=0.
- DATA:
  - At tick_cnt==OVS-1: SHIFT_EN=1, SAMPLE=RXD, tick_cnt=0, bit_cnt++.
  - After the DATA_BITS-th sample -> STOP, or PARITY when compiled in.
- STOP:
  - At tick_cnt==OVS-1: sample RXD. Any stop sample 0 marks frame error.
  - After the STOP_BITS-th sample: LOAD=1 for one cycle, RX_READY=1, FRAME_ERR=accumulated error, then -> IDLE immediately (mid stop bit, for resync).
- Handshake:
  - RX_ACK while RX_READY=1 clears RX_READY next cycle.
  - RX_ACK while RX_READY=0 is ignored.
- Overrun:
  - LOAD while RX_READY=1 and RX_ACK=0 sets OVERRUN. LOAD is still issued, so the newest byte overwrites. RX_READY stays 1; FRAME_ERR takes the new frame's value.
- Simultaneous LOAD and RX_ACK: old byte is consumed, new byte is pending, RX_READY remains 1, OVERRUN is not set.
- OVERRUN: cleared by ERR_CLR. If ERR_CLR and a new overrun coincide, set wins.
- FRAME_ERR updates only on LOAD.
- BUSY=1 in START, DATA, PARITY and STOP.

Optional Feature:
- Macro: RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP, plus output PARITY_ERR (1 bit).
  - Running XOR over the data samples; parity bit sampled at tick_cnt==OVS-1. No SHIFT_EN pulse for the parity bit.
  - PARITY_ERR = (xor_data ^ parity_sample) != PARITY_ODD. It is latched on LOAD and follows the same rules as FRAME_ERR.
- Undefined: no PARITY state, no PARITY_ERR port; DATA goes directly to STOP.

Test Plan:
- OVS=16, frame 0xA5 (start, bits 1,0,1,0,0,1,0,1, stop=1): 8 SHIFT_EN pulses 16 ticks apart, first 24 ticks after start edge, with SAMPLE 1,0,1,0,0,1,0,1 -> LOAD once, RX_READY=1, FRAME_ERR=0, BUSY low after LOAD.
- RXD low for 4 ticks then high -> return to IDLE at tick 8, no SHIFT_EN/LOAD, RX_READY stays 0.
- Frame 0x00 with stop bit 0 -> LOAD, RX_READY=1, FRAME_ERR=1; next clean 0x3C frame after RX_ACK -> FRAME_ERR=0.
- Two back-to-back frames 0x11, 0x22, no RX_ACK -> second LOAD sets OVERRUN=1, RX_READY stays 1. ERR_CLR -> OVERRUN=0.
- RX_ACK pulsed in the LOAD cycle of frame 2 -> RX_READY=1, OVERRUN=0.
- RST_N low during bit 4 of a frame -> all outputs 0 and IDLE. Next full frame 0x5A is received correctly.
- (RX_PARITY_EN, PARITY_ODD=0) frame 0x07 with parity bit 1 -> PARITY_ERR=0; same frame with parity bit 0 -> PARITY_ERR=1.
